// File: rtl/text_overlay_controller.sv
// Text overlay controller: renders an NCOLS x NROWS character window on top of
// a pixel/line scan. Three-stage pipeline (text read, glyph read, colour out)
// with per-channel colour counters stepped by rising edges on rgbIn.
// Optional feature macro: TEXT_OVERLAY_BLINK_EN (code bit 7 = blink attribute).
module text_overlay_controller #(
    parameter int HAE    = 192,
    parameter int VAE    = 316,
    parameter int NCOLS  = 16,
    parameter int NROWS  = 4,
    parameter int CHAR_H = 8,
    parameter int CW     = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [9:0]      pixelCnt,
    input  logic [8:0]      lineCnt,
    input  logic [2:0]      rgbIn,
    input  logic            wrEn,
    input  logic            wrSel,
    input  logic [10:0]     wrAddr,
    input  logic [7:0]      wrData,
    output logic [3*CW-1:0] vgaRGB
);

    localparam int NCHARS = NCOLS * NROWS;
    localparam int TXT_AW = $clog2(NCHARS);
    localparam int COLW   = $clog2(NCOLS);
    localparam int WIN_W  = 8 * NCOLS;
    localparam int WIN_H  = NROWS * CHAR_H;

    // Storage: never reset, so text and glyphs survive a reset pulse.
    logic [7:0] txt_mem   [NCHARS];
    logic [7:0] glyph_mem [2048];

    // Window decode of the current scan position.
    logic [9:0]        px_off;
    logic [8:0]        ln_off;
    logic [8:0]        row_full;
    logic              in_win;
    logic [TXT_AW-1:0] txt_idx;
    logic [2:0]        gl_w;
    logic [2:0]        bit_w;

    assign px_off   = pixelCnt - 10'(HAE);
    assign ln_off   = lineCnt - 9'(VAE);
    assign row_full = ln_off / 9'(CHAR_H);
    assign in_win   = (pixelCnt >= 10'(HAE)) && (px_off < 10'(WIN_W)) &&
                      (lineCnt >= 9'(VAE)) && (ln_off < 9'(WIN_H));
    // NCOLS is a power of two, so row*NCOLS+col is a plain concatenation.
    assign txt_idx  = TXT_AW'({row_full, px_off[3 +: COLW]});
    assign gl_w     = 3'(ln_off % 9'(CHAR_H));
    assign bit_w    = 3'd7 - px_off[2:0];

    // Pipeline registers.
    logic       s1_win_q, s2_win_q;
    logic [2:0] s1_gl_q;
    logic [2:0] s1_bit_q, s2_bit_q;
    logic [7:0] s1_code_q;
    logic [7:0] s2_glyph_q;
    logic       s2_blank_q;
    logic [3*CW-1:0] vga_q;
    logic [10:0] glyph_addr;

    // Colour state.
    logic [CW-1:0] chan_q [3];
    logic [2:0]    rgb_prev_q;
    logic          armed_q;
    logic [2:0]    rgb_rise;

`ifdef TEXT_OVERLAY_BLINK_EN
    logic [4:0] frame_q;
    logic       blank_d;

    assign glyph_addr = {1'b0, s1_code_q[6:0], s1_gl_q};
    assign blank_d    = s1_code_q[7] & frame_q[4];

    // Frame counter advances once per frame at the (0,0) scan position.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_q <= '0;
        end else if (pixelCnt == 10'd0 && lineCnt == 9'd0) begin
            frame_q <= frame_q + 5'd1;
        end
    end
`else
    assign glyph_addr = {s1_code_q, s1_gl_q};
    assign s2_blank_q = 1'b0;
`endif

    // Memory writes; blocked while reset is held, contents otherwise retained.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // nothing: memories are not cleared by reset
        end else if (wrEn) begin
            if (!wrSel) begin
                if (wrAddr < 11'(NCHARS)) begin
                    txt_mem[wrAddr[TXT_AW-1:0]] <= wrData;
                end
            end else begin
                glyph_mem[wrAddr] <= wrData;
            end
        end
    end

    // Pipeline: stage 1 text read, stage 2 glyph read, stage 3 colour out.
    // Reads see the pre-write memory contents when a write hits the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_win_q   <= 1'b0;
            s1_gl_q    <= '0;
            s1_bit_q   <= '0;
            s1_code_q  <= '0;
            s2_win_q   <= 1'b0;
            s2_bit_q   <= '0;
            s2_glyph_q <= '0;
`ifdef TEXT_OVERLAY_BLINK_EN
            s2_blank_q <= 1'b0;
`endif
            vga_q      <= '0;
        end else begin
            s1_win_q   <= in_win;
            s1_gl_q    <= gl_w;
            s1_bit_q   <= bit_w;
            s1_code_q  <= txt_mem[txt_idx];
            s2_win_q   <= s1_win_q;
            s2_bit_q   <= s1_bit_q;
            s2_glyph_q <= glyph_mem[glyph_addr];
`ifdef TEXT_OVERLAY_BLINK_EN
            s2_blank_q <= blank_d;
`endif
            if (s2_win_q && !s2_blank_q && s2_glyph_q[s2_bit_q]) begin
                vga_q <= {chan_q[2], chan_q[1], chan_q[0]};
            end else begin
                vga_q <= '0;
            end
        end
    end

    // The first clock after reset only loads the edge register, so a bit
    // already high at release does not count as a rising edge.
    assign rgb_rise = rgbIn & ~rgb_prev_q & {3{armed_q}};

    // Colour counters: each channel steps once per rising edge of its request bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rgb_prev_q <= '0;
            armed_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                chan_q[i] <= '0;
            end
        end else begin
            rgb_prev_q <= rgbIn;
            armed_q    <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (rgb_rise[i]) begin
                    chan_q[i] <= chan_q[i] + 1'b1;
                end
            end
        end
    end

    assign vgaRGB = vga_q;

endmodule

// File: doc/text_overlay_controller.md
TEXT_OVERLAY_CONTROLLER -- requirements
Module: text_overlay_controller

Interface
REQ-001 Parameter HAE, 192, first active pixelCnt of text window.
REQ-002 Parameter VAE, 316, first active lineCnt of text window.
REQ-003 Parameter NCOLS, 16, characters per text row (power of 2, ≤64).
REQ-004 Parameter NROWS, 4, text rows (power of 2, NCOLS*NROWS ≤ 256).
REQ-005 Parameter CHAR_H, 8, glyph lines per character (power of 2, ≤8); glyph width fixed at 8 pixels.
REQ-006 Parameter CW, 3, bits per colour channel.
REQ-007 Port: clock, in, 1, sole clock; all state updates on rising edge.
REQ-008 Port: reset, in, 1, asynchronous, active-low reset.
REQ-009 Port: pixelCnt, in, 10, current pixel in line.
REQ-010 Port: lineCnt, in, 9, current line in frame.
REQ-011 Port: rgbIn, in, 3, colour-step requests; bit 0 red, 1 green, 2 blue.
REQ-012 Port: wrEn, in, 1, write strobe.
REQ-013 Port: wrSel, in, 1, 0 = text buffer, 1 = glyph RAM.
REQ-014 Port: wrAddr, in, 11, text index (low bits) or {code[7:0], glyphLine[2:0]}.
REQ-015 Port: wrData, in, 8, character code or glyph line bits (bit 7 = leftmost pixel).
REQ-016 Port: vgaRGB, out, 3*CW, registered pixel colour {B, G, R}.

Function
REQ-017 Window: pixelCnt in [HAE, HAE+8*NCOLS-1] and lineCnt in [VAE, VAE+NROWS*CHAR_H-1]; outside, vgaRGB SHALL be 0.
REQ-018 col = (pixelCnt-HAE)>>3; row = (lineCnt-VAE)/CHAR_H; gl = (lineCnt-VAE) mod CHAR_H; bit = 7-((pixelCnt-HAE) mod 8); text index = row*NCOLS+col.
REQ-019 Pipeline: stage 1 registers window flag, gl, bit and reads text buffer; stage 2 reads glyph RAM at {code, gl}; stage 3 registers vgaRGB. Latency SHALL be exactly 3 clocks from pixelCnt/lineCnt to vgaRGB.
REQ-020 Inside window, glyph bit 1 -> vgaRGB = {B, G, R} colour registers; glyph bit 0 -> 0.
REQ-021 Writes occur on the clock edge with wrEn=1; writes to text index ≥ NCOLS*NROWS SHALL be ignored; glyph lines ≥ CHAR_H are stored but never displayed.
REQ-022 Same-cycle write and read of one address: read returns old data; new data visible from the next read.
REQ-023 Each colour channel is a CW-bit counter incrementing once per rising edge of its rgbIn bit (edge-detected with a registered copy of rgbIn); held high = single step.
REQ-024 Counter wraps 2^CW-1 -> 0; simultaneous edges on several bits step each channel independently in the same cycle.
REQ-025 Colour change SHALL appear on vgaRGB no later than 3 clocks after the detecting edge; no partial-channel glitch within one output word.

Reset
REQ-026 reset low SHALL immediately clear vgaRGB, colour counters, rgbIn edge register, pipeline registers and blink state to 0.
REQ-027 Text buffer and glyph RAM contents SHALL NOT be reset; writes with reset low SHALL be ignored.
REQ-028 Deassertion mid-frame: first valid output 3 clocks after the first rising edge with reset high; no spurious rgbIn edge from a bit already high at release.

Configuration
REQ-029 Macro TEXT_OVERLAY_BLINK_EN defined: code bit 7 is a blink attribute, glyph index = {1'b0, code[6:0]}; a 5-bit frame counter increments on each pixelCnt==0 && lineCnt==0 cycle, and while its MSB is 1 blink characters display as 0.
REQ-030 Macro undefined: all 8 code bits index the glyph RAM, no frame counter, no blanking.

Verification
REQ-031 After reset, write code 0x41 to text index 0, glyph {0x41,0}=0x80, step rgbIn[0] 3 times -> at (HAE,VAE) vgaRGB = 9'h003 three clocks later; (HAE+1,VAE) -> 0.
REQ-032 Red counter at 7, one rgbIn[0] pulse -> red = 0; rgbIn held high 100 clocks -> exactly one step.
REQ-033 Scan pixelCnt HAE-1 and HAE+8*NCOLS with glyph 0xFF everywhere -> vgaRGB = 0 at both; HAE+8*NCOLS-1 -> non-zero.
REQ-034 Write text index 5 with 0x22 in the cycle it is read -> old code displayed; following frame shows 0x22 glyph.
REQ-035 Assert reset low mid-window with vgaRGB non-zero -> vgaRGB = 0 before next clock edge; RAM contents intact after release.
REQ-036 TEXT_OVERLAY_BLINK_EN: code 0x81, 32 frames -> visible frames 0-15, blank 16-31; without macro code 0x81 always visible via glyph 0x81.
